// File: rtl/regfile_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : regfile_param
// Purpose  : Parametrised miniRISC register file with link write, optional
//            hardwired zero and a handshaked full-file dump engine.
//            Optional feature macro: REGF_BYPASS_EN (same-cycle read forwarding)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_IDX = DEPTH - 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] reg1_index,
    input  logic [ADDR_W-1:0] reg2_index,
    input  logic [1:0]        reg_write,
    input  logic [DATA_W-1:0] data_write,
    output logic [DATA_W-1:0] reg1_value,
    output logic [DATA_W-1:0] reg2_value,
    input  logic [ADDR_W-1:0] show_index,
    output logic [DATA_W-1:0] reg_return,
    input  logic              dump_start,
    input  logic              dump_ready,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam logic [ADDR_W-1:0] c_LINK    = ADDR_W'(LINK_IDX);
    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH - 1);
    localparam logic              c_ZERO_EN = (ZERO_REG != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [DATA_W-1:0] r_regs [DEPTH];

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [DATA_W-1:0] r_dump_data;
    logic [DATA_W-1:0] w_dump_data_nxt;

    logic [ADDR_W-1:0] w_wr_idx;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_ptr_inc;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_rd_show;
    logic [DATA_W-1:0] w_rd_cap0;
    logic [DATA_W-1:0] w_rd_capn;
    logic              w_fwd1;
    logic              w_fwd2;

    always_comb begin
        w_wr_idx = reg1_index;
        case (reg_write)
            2'b10:   w_wr_idx = reg1_index;
            2'b11:   w_wr_idx = reg2_index;
            2'b01:   w_wr_idx = c_LINK;
            default: w_wr_idx = reg1_index;
        endcase
    end

    // Writes aimed at the hardwired zero register are discarded here so that
    // the forwarding path inherits the same exception for free.
    assign w_wr_en = (reg_write != 2'b00) && !(c_ZERO_EN && (w_wr_idx == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[w_wr_idx] <= data_write;
        end
    end

    assign w_ptr_inc = r_ptr + 1'b1;

    assign w_rd1     = (c_ZERO_EN && (reg1_index == '0)) ? '0 : r_regs[reg1_index];
    assign w_rd2     = (c_ZERO_EN && (reg2_index == '0)) ? '0 : r_regs[reg2_index];
    assign w_rd_show = (c_ZERO_EN && (show_index == '0)) ? '0 : r_regs[show_index];
    assign w_rd_cap0 = c_ZERO_EN ? '0 : r_regs[0];
    assign w_rd_capn = (c_ZERO_EN && (w_ptr_inc == '0)) ? '0 : r_regs[w_ptr_inc];

`ifdef REGF_BYPASS_EN
    assign w_fwd1 = w_wr_en && (w_wr_idx == reg1_index);
    assign w_fwd2 = w_wr_en && (w_wr_idx == reg2_index);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    assign reg1_value = w_fwd1 ? data_write : w_rd1;
    assign reg2_value = w_fwd2 ? data_write : w_rd2;
    assign reg_return = w_rd_show;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_dump_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_dump_data <= w_dump_data_nxt;
        end
    end

    // Captures sample stored contents only, so a write on the capture edge
    // never leaks into the beat it lands on.
    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_dump_data_nxt = r_dump_data;
        case (r_state)
            S_IDLE: begin
                if (dump_start) begin
                    w_state_nxt     = S_RUN;
                    w_ptr_nxt       = '0;
                    w_dump_data_nxt = w_rd_cap0;
                end
            end
            S_RUN: begin
                if (dump_ready) begin
                    if (r_ptr == c_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_ptr_nxt       = w_ptr_inc;
                        w_dump_data_nxt = w_rd_capn;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign dump_valid = (r_state == S_RUN);
    assign dump_busy  = (r_state == S_RUN) || (r_state == S_DONE);
    assign dump_done  = (r_state == S_DONE);
    assign dump_index = r_ptr;
    assign dump_data  = r_dump_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_regfile_param
// Purpose  : Self-checking bench for regfile_param against an array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_param;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] reg1_index;
    logic [ADDR_W-1:0] reg2_index;
    logic [1:0]        reg_write;
    logic [DATA_W-1:0] data_write;
    logic [DATA_W-1:0] reg1_value;
    logic [DATA_W-1:0] reg2_value;
    logic [ADDR_W-1:0] show_index;
    logic [DATA_W-1:0] reg_return;
    logic              dump_start;
    logic              dump_ready;
    logic              dump_valid;
    logic [ADDR_W-1:0] dump_index;
    logic [DATA_W-1:0] dump_data;
    logic              dump_busy;
    logic              dump_done;

    int checks;
    int failures;

    logic [DATA_W-1:0] model [DEPTH];

    regfile_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .LINK_IDX(DEPTH - 1),
        .ZERO_REG(1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .reg1_index(reg1_index),
        .reg2_index(reg2_index),
        .reg_write (reg_write),
        .data_write(data_write),
        .reg1_value(reg1_value),
        .reg2_value(reg2_value),
        .show_index(show_index),
        .reg_return(reg_return),
        .dump_start(dump_start),
        .dump_ready(dump_ready),
        .dump_valid(dump_valid),
        .dump_index(dump_index),
        .dump_data (dump_data),
        .dump_busy (dump_busy),
        .dump_done (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mread(input int idx);
        return (idx == 0) ? '0 : model[idx];
    endfunction

    function automatic int target(input logic [1:0] mode, input int i1, input int i2);
        case (mode)
            2'b10:   return i1;
            2'b11:   return i2;
            2'b01:   return DEPTH - 1;
            default: return -1;
        endcase
    endfunction

    function automatic void mwrite(input logic [1:0] mode, input int i1, input int i2,
                                   input logic [DATA_W-1:0] d);
        int t;
        t = target(mode, i1, i2);
        if (t > 0) model[t] = d;
    endfunction

    // Forwarded value expected on a read port while a write is pending this cycle.
    function automatic logic [DATA_W-1:0] port_exp(input int idx, input logic [1:0] mode,
                                                   input int i1, input int i2,
                                                   input logic [DATA_W-1:0] d);
`ifdef REGF_BYPASS_EN
        if (idx != 0 && target(mode, i1, i2) == idx) return d;
`endif
        return mread(idx);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] mode, input int i1, input int i2,
                            input logic [DATA_W-1:0] d);
        reg_write  = mode;
        reg1_index = ADDR_W'(i1);
        reg2_index = ADDR_W'(i2);
        data_write = d;
        tick();
        mwrite(mode, i1, i2, d);
        reg_write = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: valid=%b busy=%b done=%b required 000",
                     dump_valid, dump_busy, dump_done);
        end
        checks++;
        if (dump_index !== '0 || dump_data !== '0) begin
            failures++;
            $display("FAIL reset_dump_regs: index=%0d data=%h required 0/0", dump_index, dump_data);
        end
        rst = 1'b0;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            show_index = ADDR_W'(i);
            #0.1;
            checks++;
            if (reg_return !== '0) begin
                failures++;
                $display("FAIL reset_reg: r%0d=%h required 0", i, reg_return);
            end
        end
    endtask

    task automatic test_write_modes();
        do_write(2'b10, 1, 0, 32'd16);
        do_write(2'b11, 0, 2, 32'd22);
        reg1_index = 1; reg2_index = 2; show_index = 2;
        #1;
        checks++;
        if (reg1_value !== 32'd16 || reg2_value !== 32'd22 || reg_return !== 32'd22) begin
            failures++;
            $display("FAIL write_10_11: r1=%0d r2=%0d ret=%0d required 16/22/22",
                     reg1_value, reg2_value, reg_return);
        end
        do_write(2'b01, 7, 8, 32'd9);
        reg1_index = 1; reg2_index = 2; show_index = 31;
        #1;
        checks++;
        if (reg_return !== 32'd9 || reg1_value !== 32'd16 || reg2_value !== 32'd22) begin
            failures++;
            $display("FAIL write_link: r31=%0d r1=%0d r2=%0d required 9/16/22",
                     reg_return, reg1_value, reg2_value);
        end
        do_write(2'b10, 0, 0, 32'd5);
        reg1_index = 0; show_index = 0;
        #1;
        checks++;
        if (reg1_value !== '0 || reg_return !== '0) begin
            failures++;
            $display("FAIL zero_reg: r1=%0d ret=%0d required 0/0", reg1_value, reg_return);
        end
    endtask

    task automatic test_bypass();
        reg_write  = 2'b10;
        reg1_index = 3;
        reg2_index = 4;
        show_index = 3;
        data_write = 32'h55;
        #1;
        checks++;
        if (reg1_value !== port_exp(3, 2'b10, 3, 4, 32'h55)) begin
            failures++;
            $display("FAIL bypass_r1: got %h required %h", reg1_value, port_exp(3, 2'b10, 3, 4, 32'h55));
        end
        checks++;
        if (reg_return !== mread(3)) begin
            failures++;
            $display("FAIL bypass_ret: got %h required %h", reg_return, mread(3));
        end
        tick();
        mwrite(2'b10, 3, 4, 32'h55);
        reg_write  = 2'b11;
        reg1_index = 0;
        reg2_index = 0;
        data_write = 32'hDEAD;
        #1;
        checks++;
        if (reg2_value !== '0 || reg1_value !== '0) begin
            failures++;
            $display("FAIL bypass_zero: r1=%h r2=%h required 0/0", reg1_value, reg2_value);
        end
        reg_write = 2'b00;
        tick();
    endtask

    task automatic test_random_rw();
        logic [1:0]        m;
        int                i1, i2, sh;
        logic [DATA_W-1:0] d;
        for (int n = 0; n < 80; n++) begin
            m  = 2'($urandom_range(0, 3));
            i1 = $urandom_range(0, DEPTH - 1);
            i2 = $urandom_range(0, DEPTH - 1);
            sh = $urandom_range(0, DEPTH - 1);
            d  = $urandom;
            reg_write = m; reg1_index = ADDR_W'(i1); reg2_index = ADDR_W'(i2);
            show_index = ADDR_W'(sh); data_write = d;
            #1;
            checks++;
            if (reg1_value !== port_exp(i1, m, i1, i2, d) || reg2_value !== port_exp(i2, m, i1, i2, d)
                || reg_return !== mread(sh)) begin
                failures++;
                $display("FAIL rand_rw[%0d]: r1=%h r2=%h ret=%h required %h/%h/%h", n,
                         reg1_value, reg2_value, reg_return,
                         port_exp(i1, m, i1, i2, d), port_exp(i2, m, i1, i2, d), mread(sh));
            end
            tick();
            mwrite(m, i1, i2, d);
        end
        reg_write = 2'b00;
    endtask

    task automatic test_dump_full();
        int busy_cycles;
        for (int i = 1; i < DEPTH; i++) do_write(2'b10, i, 0, DATA_W'(i + 100));
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        busy_cycles = 0;
        for (int b = 0; b < DEPTH; b++) begin
            checks++;
            if (dump_valid !== 1'b1 || dump_index !== ADDR_W'(b) || dump_data !== mread(b)) begin
                failures++;
                $display("FAIL dump_beat[%0d]: valid=%b idx=%0d data=%0d required 1/%0d/%0d",
                         b, dump_valid, dump_index, dump_data, b, mread(b));
            end
            if (dump_busy) busy_cycles++;
            tick();
        end
        checks++;
        if (dump_done !== 1'b1 || dump_valid !== 1'b0 || dump_busy !== 1'b1) begin
            failures++;
            $display("FAIL dump_done_pulse: done=%b valid=%b busy=%b required 1/0/1",
                     dump_done, dump_valid, dump_busy);
        end
        if (dump_busy) busy_cycles++;
        tick();
        checks++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0 || busy_cycles != DEPTH + 1) begin
            failures++;
            $display("FAIL dump_end: done=%b busy=%b busy_cycles=%0d required 0/0/%0d",
                     dump_done, dump_busy, busy_cycles, DEPTH + 1);
        end
    endtask

    task automatic test_dump_stall();
        int                exp_idx, accepted, cycles, phase, widx;
        logic [DATA_W-1:0] exp_data, wd;
        logic              rdy, wr, saw_done;
        exp_idx  = 0;
        exp_data = mread(0);
        accepted = 0;
        cycles   = 0;
        phase    = 0;
        saw_done = 1'b0;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        while (!saw_done && cycles < 400) begin
            if (phase == 1) begin
                checks++;
                if (dump_done !== 1'b1 || dump_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL stall_done: done=%b valid=%b required 1/0", dump_done, dump_valid);
                end
                saw_done = 1'b1;
            end else begin
                checks++;
                if (dump_valid !== 1'b1 || dump_busy !== 1'b1 || dump_index !== ADDR_W'(exp_idx)
                    || dump_data !== exp_data) begin
                    failures++;
                    $display("FAIL stall_beat: valid=%b busy=%b idx=%0d data=%h required 1/1/%0d/%h",
                             dump_valid, dump_busy, dump_index, dump_data, exp_idx, exp_data);
                end
                rdy  = (cycles % 2 == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                wr   = ($urandom_range(0, 2) != 0);
                widx = (!rdy || $urandom_range(0, 1) == 1) ? exp_idx : $urandom_range(0, DEPTH - 1);
                wd   = $urandom;
                dump_ready = rdy;
                reg_write  = wr ? 2'b10 : 2'b00;
                reg1_index = ADDR_W'(widx);
                data_write = wd;
                if (rdy) begin
                    accepted++;
                    if (exp_idx == DEPTH - 1) begin
                        phase = 1;
                    end else begin
                        exp_idx++;
                        exp_data = mread(exp_idx);
                    end
                end
                if (wr) mwrite(2'b10, widx, 0, wd);
            end
            tick();
            cycles++;
        end
        reg_write  = 2'b00;
        dump_ready = 1'b0;
        checks++;
        if (!saw_done || accepted != DEPTH || dump_busy !== 1'b0) begin
            failures++;
            $display("FAIL stall_summary: done_seen=%b beats=%0d busy=%b required 1/%0d/0",
                     saw_done, accepted, dump_busy, DEPTH);
        end
    endtask

    task automatic test_reset_mid_dump();
        int done_seen;
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        repeat (10) tick();
        checks++;
        if (dump_index !== ADDR_W'(10) || dump_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_abort: idx=%0d valid=%b required 10/1", dump_index, dump_valid);
        end
        rst = 1'b1;
        #0.5;
        checks++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0 || dump_index !== '0) begin
            failures++;
            $display("FAIL abort_flags: valid=%b busy=%b done=%b idx=%0d required 0/0/0/0",
                     dump_valid, dump_busy, dump_done, dump_index);
        end
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            show_index = ADDR_W'(i);
            #0.1;
            checks++;
            if (reg_return !== '0) begin
                failures++;
                $display("FAIL abort_reg: r%0d=%h required 0", i, reg_return);
            end
        end
        rst = 1'b0;
        done_seen = 0;
        repeat (3) begin
            tick();
            if (dump_done !== 1'b0 || dump_busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL abort_no_done: spurious cycles=%0d required 0", done_seen);
        end
        do_write(2'b10, 5, 0, 32'h1234);
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        checks++;
        if (dump_valid !== 1'b1 || dump_index !== '0 || dump_data !== '0) begin
            failures++;
            $display("FAIL restart: valid=%b idx=%0d data=%h required 1/0/0",
                     dump_valid, dump_index, dump_data);
        end
        repeat (5) tick();
        checks++;
        if (dump_index !== ADDR_W'(5) || dump_data !== 32'h1234) begin
            failures++;
            $display("FAIL restart_beat5: idx=%0d data=%h required 5/1234", dump_index, dump_data);
        end
        repeat (DEPTH) tick();
        dump_ready = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        reg1_index = '0;
        reg2_index = '0;
        reg_write  = 2'b00;
        data_write = '0;
        show_index = '0;
        dump_start = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        #1;
        test_reset();
        test_write_modes();
        test_bypass();
        test_random_rw();
        test_dump_full();
        test_dump_stall();
        test_reset_mid_dump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_param.md
# regfile_param

Parametrised general-purpose register file for the miniRISC datapath: the successor to the fixed 32x32 register module. It adds configurable width and depth, a hardwired-zero option, a configurable link-register target and a handshaked debug dump engine. It also provides optional same-cycle write-to-read forwarding. It sits between decode (index inputs) and the ALU/writeback stage; the dump port feeds the board display/debug logic.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of registers (power of two, >= 4)
- ADDR_W, 5, index width; must equal log2(DEPTH)
- LINK_IDX, DEPTH-1, register written by link-write mode
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- reg1_index  in  ADDR_W  read port 1 index / write target for mode 10
- reg2_index  in  ADDR_W  read port 2 index / write target for mode 11
- reg_write  in  2  write mode: 00 none, 10 write reg1_index, 11 write reg2_index, 01 write LINK_IDX
- data_write  in  DATA_W  write data
- reg1_value  out  DATA_W  contents of reg1_index (combinational)
- reg2_value  out  DATA_W  contents of reg2_index (combinational)
- show_index  in  ADDR_W  display select
- reg_return  out  DATA_W  contents of show_index (combinational, never forwarded)
- dump_start  in  1  request full-file dump (sampled only in IDLE)
- dump_ready  in  1  consumer accepts current dump beat
- dump_valid  out  1  dump beat valid
- dump_index  out  ADDR_W  index of current beat
- dump_data  out  DATA_W  captured value of current beat
- dump_busy  out  1  high in RUN and DONE
- dump_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Write: on rising edge, if reg_write != 00, the target register is loaded with data_write. If ZERO_REG=1 and the target is 0, the write is dropped.
- Reads: reg1_value, reg2_value and reg_return are combinational from current contents. Register 0 reads 0 when ZERO_REG=1.
- Dump FSM states:
  - IDLE: dump_valid=0, dump_busy=0. dump_start=1 moves to RUN, sets ptr=0 and captures reg[0] into dump_data.
  - RUN: dump_valid=1, dump_index=ptr. When dump_valid && dump_ready:
    - if ptr==DEPTH-1, go to DONE;
    - otherwise increment ptr and capture reg[ptr+1].
  - DONE: dump_done=1 for one cycle, dump_valid=0, then return to IDLE.
- Capture semantics: a capture takes the pre-edge contents. A write on the same edge is not visible in that beat. dump_data and dump_index hold stable while dump_valid && !dump_ready, even if the register is written meanwhile.
- dump_start is ignored outside IDLE.
- Register writes and reads proceed normally during a dump.

## Timing
- Reset (async assert): all registers 0, FSM IDLE, ptr 0, dump_valid/dump_busy/dump_done 0, dump_index 0, dump_data 0.
- Reset mid-dump aborts immediately, with no done pulse.
- Write latency: one edge. The value is visible on read ports in the following cycle.
- Dump: dump_start high at edge N gives dump_valid at cycle N+1 with index 0.
  - With dump_ready held high: DEPTH consecutive beats, dump_done in cycle N+DEPTH+1, IDLE after that.
  - dump_busy spans DEPTH+1 cycles.
- A new dump may start on the cycle after DONE.
- Index arithmetic is ADDR_W bits; ptr never wraps because termination is at DEPTH-1.

## Configuration
- REGF_BYPASS_EN defined: if reg_write targets the index on reg1_index (or reg2_index) in the same cycle, that read port returns data_write combinationally. The ZERO_REG exception still applies. reg_return and dump capture are unaffected.
- REGF_BYPASS_EN undefined: read ports return the stored (pre-edge) value; no forwarding path exists.

## Test plan
- Reset, then mode 10 with reg1_index=1, data 16; mode 11 with reg2_index=2, data 22 -> reg1_value=16, reg2_value=22; show_index=2 gives reg_return=22.
- Mode 01 with data 9 -> register 31 = 9 and registers 1/2 unchanged. Mode 10 with reg1_index=0, data 5 -> reads 0 (ZERO_REG=1).
- Same-cycle write reg 3 = 0x55 with reg1_index=3 -> reg1_value=0x55 combinationally with REGF_BYPASS_EN, and old value 0 without it.
- Registers preloaded with r[i]=i+100, dump_start pulse, dump_ready=1 -> 32 beats, index 0..31, data 0 (r0 zero), 101..131, then dump_done one cycle.
- Dump with dump_ready toggling 1/0 and a write to the currently presented index while stalled -> dump_index/dump_data held, no beat lost or duplicated, captured old value shown.
- Assert rst during beat 10 -> dump_valid/dump_busy drop immediately, all registers 0, no dump_done; a new dump_start afterwards begins at index 0.
